// File: rtl/dc_sweep_sequencer_pkg.sv
// Shared types for the DC-sweep sequencer: FSM state encoding, sample record
// layout and the default widths used by the fixture.
package dc_sweep_sequencer_pkg;

    localparam int DEF_DAC_W    = 12;
    localparam int DEF_ADC_W    = 16;
    localparam int DEF_SETTLE_W = 16;
    localparam int DEF_IDX_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        REQ,
        OUT,
        DONE
    } state_t;

    typedef struct packed {
        logic [DEF_IDX_W-1:0] gidx;
        logic [DEF_IDX_W-1:0] didx;
        logic [DEF_ADC_W-1:0] data;
        logic                 last;
    } sample_rec_t;

endpackage

// File: rtl/dc_sweep_sequencer_if.sv
// ADC request/acknowledge handshake plus the outgoing sample stream.
// The sequencer takes the master side; the ADC and sample FIFO take the slave side.
interface dc_sweep_sequencer_if #(
    parameter int ADC_W = dc_sweep_sequencer_pkg::DEF_ADC_W,
    parameter int IDX_W = dc_sweep_sequencer_pkg::DEF_IDX_W
) ();

    logic             adc_req;
    logic             adc_ack;
    logic [ADC_W-1:0] adc_data;

    logic             s_valid;
    logic             s_ready;
    logic [IDX_W-1:0] s_gidx;
    logic [IDX_W-1:0] s_didx;
    logic [ADC_W-1:0] s_data;
    logic             s_last;

    modport master (
        output adc_req,
        input  adc_ack,
        input  adc_data,
        output s_valid,
        input  s_ready,
        output s_gidx,
        output s_didx,
        output s_data,
        output s_last
    );

    modport slave (
        input  adc_req,
        output adc_ack,
        output adc_data,
        input  s_valid,
        output s_ready,
        input  s_gidx,
        input  s_didx,
        input  s_data,
        input  s_last
    );

endinterface

// File: rtl/dc_sweep_sequencer_sweep_axis_counter.sv
// One bias axis of the sweep: latches start/step/count on load and walks the
// DAC code and point index, reporting when the final point is reached.
module sweep_axis_counter
    import dc_sweep_sequencer_pkg::*;
#(
    parameter int DAC_W = DEF_DAC_W,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DAC_W-1:0] start_code,
    input  logic [DAC_W-1:0] step_code,
    input  logic [IDX_W-1:0] count,
    input  logic             step,
    input  logic             wrap,
    output logic [DAC_W-1:0] code,
    output logic [IDX_W-1:0] idx,
    output logic             is_last
);

    logic [DAC_W-1:0] start_q;
    logic [DAC_W-1:0] step_q;
    logic [IDX_W-1:0] last_q;

    // A zero point count is treated as a single point; code arithmetic wraps freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
            step_q  <= '0;
            last_q  <= '0;
            code    <= '0;
            idx     <= '0;
        end else if (load) begin
            start_q <= start_code;
            step_q  <= step_code;
            last_q  <= (count == '0) ? '0 : count - 1'b1;
            code    <= start_code;
            idx     <= '0;
        end else if (wrap) begin
            code <= start_q;
            idx  <= '0;
        end else if (step) begin
            code <= code + step_q;
            idx  <= idx + 1'b1;
        end
    end

    assign is_last = (idx == last_q);

endmodule

// File: rtl/dc_sweep_sequencer.sv
// DC-sweep engine: gate bias outer loop, drain bias inner loop; at each point it
// settles, takes one ADC conversion and emits a tagged sample record.
module dc_sweep_sequencer
    import dc_sweep_sequencer_pkg::*;
#(
    parameter int DAC_W    = DEF_DAC_W,
    parameter int ADC_W    = DEF_ADC_W,
    parameter int SETTLE_W = DEF_SETTLE_W,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [DAC_W-1:0]    vg_start,
    input  logic [DAC_W-1:0]    vg_step,
    input  logic [IDX_W-1:0]    vg_count,
    input  logic [DAC_W-1:0]    vd_start,
    input  logic [DAC_W-1:0]    vd_step,
    input  logic [IDX_W-1:0]    vd_count,
    input  logic [SETTLE_W-1:0] settle,
    output logic [DAC_W-1:0]    dac_vg,
    output logic [DAC_W-1:0]    dac_vd,
    output logic                dac_load,
    dc_sweep_sequencer_if.master sif,
    output logic                busy,
    output logic                done
);

    state_t state_q, state_d;

    logic                axis_load;
    logic                d_step, d_wrap, g_step;
    logic [IDX_W-1:0]    g_idx, d_idx;
    logic                g_last, d_last;
    logic [SETTLE_W-1:0] settle_q, settle_cnt;
    sample_rec_t         rec_q;

    sweep_axis_counter #(.DAC_W(DAC_W), .IDX_W(IDX_W)) u_gate (
        .clk(clk), .rst(rst), .load(axis_load),
        .start_code(vg_start), .step_code(vg_step), .count(vg_count),
        .step(g_step), .wrap(1'b0),
        .code(dac_vg), .idx(g_idx), .is_last(g_last)
    );

    sweep_axis_counter #(.DAC_W(DAC_W), .IDX_W(IDX_W)) u_drain (
        .clk(clk), .rst(rst), .load(axis_load),
        .start_code(vd_start), .step_code(vd_step), .count(vd_count),
        .step(d_step), .wrap(d_wrap),
        .code(dac_vd), .idx(d_idx), .is_last(d_last)
    );

    // Next-state and axis control; abort overrides everything and freezes the codes.
    always_comb begin
        state_d   = state_q;
        axis_load = 1'b0;
        d_step    = 1'b0;
        d_wrap    = 1'b0;
        g_step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    axis_load = 1'b1;
                end
            end
            LOAD:   state_d = SETTLE;
            SETTLE: if (settle_cnt == '0) state_d = REQ;
            REQ:    if (sif.adc_ack) state_d = OUT;
            OUT: begin
                if (sif.s_ready) begin
                    if (!d_last) begin
                        d_step  = 1'b1;
                        state_d = LOAD;
                    end else if (!g_last) begin
                        d_wrap  = 1'b1;
                        g_step  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            axis_load = 1'b0;
            d_step    = 1'b0;
            d_wrap    = 1'b0;
            g_step    = 1'b0;
        end
    end

    // Settle interval is latched with the rest of the config and reloaded at every LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            settle_cnt <= '0;
            rec_q      <= '0;
        end else begin
            state_q <= state_d;
            if (axis_load) settle_q <= settle;
            if (state_q == LOAD) begin
                settle_cnt <= settle_q;
            end else if (state_q == SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (state_q == REQ && sif.adc_ack && !abort) begin
                rec_q <= '{gidx: g_idx, didx: d_idx, data: sif.adc_data, last: g_last && d_last};
            end
        end
    end

    assign dac_load    = (state_q == LOAD);
    assign sif.adc_req = (state_q == REQ);
    assign sif.s_valid = (state_q == OUT);
    assign sif.s_gidx  = rec_q.gidx;
    assign sif.s_didx  = rec_q.didx;
    assign sif.s_data  = rec_q.data;
    assign sif.s_last  = rec_q.last;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_dc_sweep_sequencer.sv
// Directed bench for the DC-sweep sequencer: a behavioural ADC answers each
// request after a fixed delay with the running point number as its data.
module tb_dc_sweep_sequencer;

    localparam int DAC_W    = 12;
    localparam int ADC_W    = 16;
    localparam int SETTLE_W = 16;
    localparam int IDX_W    = 8;

    logic                clk;
    logic                rst;
    logic                start;
    logic                abort;
    logic [DAC_W-1:0]    vg_start, vg_step, vd_start, vd_step;
    logic [IDX_W-1:0]    vg_count, vd_count;
    logic [SETTLE_W-1:0] settle;
    logic [DAC_W-1:0]    dac_vg, dac_vd;
    logic                dac_load;
    logic                busy;
    logic                done;

    int errors = 0;
    int checks = 0;

    dc_sweep_sequencer_if #(.ADC_W(ADC_W), .IDX_W(IDX_W)) sif ();

    dc_sweep_sequencer #(
        .DAC_W(DAC_W), .ADC_W(ADC_W), .SETTLE_W(SETTLE_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vg_start(vg_start), .vg_step(vg_step), .vg_count(vg_count),
        .vd_start(vd_start), .vd_step(vd_step), .vd_count(vd_count),
        .settle(settle),
        .dac_vg(dac_vg), .dac_vd(dac_vd), .dac_load(dac_load),
        .sif(sif),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: acknowledges ack_delay cycles after a request, data = point number.
    int ack_delay = 3;
    int adc_wait  = 0;
    int adc_point = 0;
    always @(negedge clk) begin
        if (sif.adc_req === 1'b1 && sif.adc_ack !== 1'b1) begin
            adc_wait = adc_wait + 1;
            if (adc_wait >= ack_delay) begin
                sif.adc_ack  = 1'b1;
                sif.adc_data = 16'(adc_point);
                adc_point    = adc_point + 1;
                adc_wait     = 0;
            end
        end else begin
            sif.adc_ack = 1'b0;
            if (sif.adc_req !== 1'b1) adc_wait = 0;
        end
    end

    // Monitor sampled 1ns before each rising edge.
    logic [32:0] rec_q[$];
    logic [23:0] load_q[$];
    int          load_cyc_q[$];
    int          req_cyc_q[$];
    int          done_cnt = 0;
    int          cycle    = 0;
    logic        req_prev = 1'b0;
    always @(negedge clk) begin
        #4;
        cycle = cycle + 1;
        if (sif.s_valid && sif.s_ready) rec_q.push_back({sif.s_last, sif.s_gidx, sif.s_didx, sif.s_data});
        if (dac_load) begin
            load_q.push_back({dac_vg, dac_vd});
            load_cyc_q.push_back(cycle);
        end
        if (sif.adc_req && !req_prev) req_cyc_q.push_back(cycle);
        req_prev = sif.adc_req;
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic clear_logs();
        rec_q.delete();
        load_q.delete();
        load_cyc_q.delete();
        req_cyc_q.delete();
        done_cnt  = 0;
        adc_point = 0;
    endtask

    task automatic set_config(input int gs, input int gst, input int gc,
                              input int ds, input int dst, input int dc, input int st);
        vg_start = DAC_W'(gs);
        vg_step  = DAC_W'(gst);
        vg_count = IDX_W'(gc);
        vd_start = DAC_W'(ds);
        vd_step  = DAC_W'(dst);
        vd_count = IDX_W'(dc);
        settle   = SETTLE_W'(st);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt != 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({dac_vg, dac_vd} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_dac: got %h expected 000000", {dac_vg, dac_vd});
        end
        checks++;
        if ({busy, done, dac_load, sif.adc_req, sif.s_valid, sif.s_last} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {busy, done, dac_load, sif.adc_req, sif.s_valid, sif.s_last});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_basic_sweep();
        logic [7:0]  exp_g  [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
        logic [7:0]  exp_d  [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
        logic [11:0] exp_vg [6] = '{12'd100, 12'd100, 12'd100, 12'd110, 12'd110, 12'd110};
        logic [11:0] exp_vd [6] = '{12'd0, 12'd50, 12'd100, 12'd0, 12'd50, 12'd100};
        logic [32:0] exp_rec, got_rec;
        logic [23:0] got_ld;
        bit ok;
        set_config(100, 10, 2, 0, 50, 3, 2);
        clear_logs();
        pulse_start();
        wait_done(400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL basic_timeout: done got 0 expected 1");
        end
        checks++;
        if (rec_q.size() != 6) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d records expected 6", rec_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            exp_rec = {(i == 5), exp_g[i], exp_d[i], 16'(i)};
            got_rec = (i < rec_q.size()) ? rec_q[i] : 'x;
            checks++;
            if (got_rec !== exp_rec) begin
                errors++;
                $display("[TB] FAIL basic_rec%0d: got %h expected %h", i, got_rec, exp_rec);
            end
            got_ld = (i < load_q.size()) ? load_q[i] : 'x;
            checks++;
            if (got_ld !== {exp_vg[i], exp_vd[i]}) begin
                errors++;
                $display("[TB] FAIL basic_load%0d: got %h expected %h", i, got_ld, {exp_vg[i], exp_vd[i]});
            end
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done: got done_cnt=%0d busy=%b expected 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_vd [6] = '{12'd0, 12'd50, 12'd100, 12'd0, 12'd50, 12'd100};
        logic [11:0] exp_vg [6] = '{12'd100, 12'd100, 12'd100, 12'd110, 12'd110, 12'd110};
        logic [23:0] got_ld;
        logic [32:0] got_rec;
        int n, loads_before, reqs_before;
        bit ok;
        set_config(100, 10, 2, 0, 50, 3, 2);
        clear_logs();
        pulse_start();
        vd_step = 12'd7;
        vg_step = 12'd99;
        n = 0;
        while (rec_q.size() < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        sif.s_ready = 1'b0;
        n = 0;
        while (sif.s_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sif.s_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_valid_timeout: s_valid got %b expected 1", sif.s_valid);
        end
        loads_before = load_q.size();
        reqs_before  = req_cyc_q.size();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({sif.s_valid, sif.s_last, sif.s_gidx, sif.s_didx, sif.s_data} !== {1'b1, 1'b0, 8'd0, 8'd1, 16'd1}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got %h expected %h", i,
                         {sif.s_valid, sif.s_last, sif.s_gidx, sif.s_didx, sif.s_data},
                         {1'b1, 1'b0, 8'd0, 8'd1, 16'd1});
            end
            @(negedge clk);
        end
        checks++;
        if (load_q.size() != loads_before || req_cyc_q.size() != reqs_before) begin
            errors++;
            $display("[TB] FAIL bp_stalled: got loads=%0d reqs=%0d expected %0d/%0d",
                     load_q.size(), req_cyc_q.size(), loads_before, reqs_before);
        end
        sif.s_ready = 1'b1;
        wait_done(400, ok);
        got_rec = (rec_q.size() == 6) ? rec_q[5] : 'x;
        checks++;
        if (!ok || got_rec !== {1'b1, 8'd1, 8'd2, 16'd5}) begin
            errors++;
            $display("[TB] FAIL bp_final: got done=%0b last_rec=%h expected 1/%h", ok, got_rec, {1'b1, 8'd1, 8'd2, 16'd5});
        end
        for (int i = 0; i < 6; i++) begin
            got_ld = (i < load_q.size()) ? load_q[i] : 'x;
            checks++;
            if (got_ld !== {exp_vg[i], exp_vd[i]}) begin
                errors++;
                $display("[TB] FAIL bp_latched_cfg%0d: got %h expected %h", i, got_ld, {exp_vg[i], exp_vd[i]});
            end
        end
    endtask

    task automatic test_single_point();
        logic [32:0] got_rec;
        int spacing;
        bit ok;
        set_config(7, 3, 0, 9, 5, 0, 0);
        clear_logs();
        pulse_start();
        wait_done(100, ok);
        got_rec = (rec_q.size() == 1) ? rec_q[0] : 'x;
        checks++;
        if (!ok || got_rec !== {1'b1, 8'd0, 8'd0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL single_rec: got done=%0b rec=%h count=%0d expected 1/%h/1",
                     ok, got_rec, rec_q.size(), {1'b1, 8'd0, 8'd0, 16'd0});
        end
        checks++;
        if (load_q.size() != 1 || load_q[0] !== {12'd7, 12'd9}) begin
            errors++;
            $display("[TB] FAIL single_load: got %0d loads first=%h expected 1/%h",
                     load_q.size(), (load_q.size() > 0) ? load_q[0] : 24'h0, {12'd7, 12'd9});
        end
        spacing = (load_cyc_q.size() > 0 && req_cyc_q.size() > 0) ? req_cyc_q[0] - load_cyc_q[0] : -1;
        checks++;
        if (spacing != 2) begin
            errors++;
            $display("[TB] FAIL single_spacing: got %0d expected 2", spacing);
        end
    endtask

    task automatic test_code_wrap();
        logic [23:0] got_ld;
        bit ok;
        set_config(5, 1, 1, 4090, 10, 2, 0);
        clear_logs();
        pulse_start();
        wait_done(100, ok);
        got_ld = (load_q.size() == 2) ? load_q[1] : 'x;
        checks++;
        if (!ok || got_ld !== {12'd5, 12'd4}) begin
            errors++;
            $display("[TB] FAIL wrap_vd: got done=%0b load=%h expected 1/%h", ok, got_ld, {12'd5, 12'd4});
        end
        checks++;
        if (rec_q.size() != 2 || rec_q[1] !== {1'b1, 8'd0, 8'd1, 16'd1}) begin
            errors++;
            $display("[TB] FAIL wrap_last: got count=%0d expected 2 with final %h", rec_q.size(), {1'b1, 8'd0, 8'd1, 16'd1});
        end
    endtask

    task automatic test_abort();
        logic [32:0] got_rec;
        int n;
        bit ok;
        set_config(100, 10, 2, 0, 50, 3, 2);
        clear_logs();
        pulse_start();
        n = 0;
        while (sif.adc_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sif.adc_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_req_timeout: adc_req got %b expected 1", sif.adc_req);
        end
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if ({sif.adc_req, busy, sif.s_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL abort_idle: got req/busy/valid=%b expected 000", {sif.adc_req, busy, sif.s_valid});
        end
        checks++;
        if ({dac_vg, dac_vd} !== {12'd100, 12'd0}) begin
            errors++;
            $display("[TB] FAIL abort_dac_hold: got %h expected %h", {dac_vg, dac_vd}, {12'd100, 12'd0});
        end
        abort = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt != 0 || rec_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got done_cnt=%0d records=%0d expected 0/0", done_cnt, rec_q.size());
        end
        clear_logs();
        pulse_start();
        wait_done(400, ok);
        got_rec = (rec_q.size() == 6) ? rec_q[5] : 'x;
        checks++;
        if (!ok || done_cnt != 1 || got_rec !== {1'b1, 8'd1, 8'd2, 16'd5}) begin
            errors++;
            $display("[TB] FAIL abort_restart: got done_cnt=%0d count=%0d last=%h expected 1/6/%h",
                     done_cnt, rec_q.size(), got_rec, {1'b1, 8'd1, 8'd2, 16'd5});
        end
    endtask

    task automatic test_reset_mid_settle();
        int n;
        set_config(100, 10, 2, 50, 50, 3, 2);
        clear_logs();
        pulse_start();
        n = 0;
        while (dac_load !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if ({busy, dac_vg, dac_vd} !== {1'b1, 12'd100, 12'd50}) begin
            errors++;
            $display("[TB] FAIL settle_pre_reset: got %h expected %h", {busy, dac_vg, dac_vd}, {1'b1, 12'd100, 12'd50});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, sif.s_valid, dac_vg, dac_vd} !== 26'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected 0", {busy, sif.s_valid, dac_vg, dac_vd});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        sif.s_ready = 1'b1;
        set_config(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic_sweep();
        test_backpressure();
        test_single_point();
        test_code_wrap();
        test_abort();
        test_reset_mid_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
